// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: MSB-first bit stream, comma-based byte alignment,
// one byte presented every 8 clk_32f edges once lock is declared.
module serial_paralelo_rx #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter int         COM_COUNT  = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  localparam logic [3:0] COM_COUNT_L = 4'(COM_COUNT);

  state_t     state;
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] com_cnt;
  logic [7:0] w;
  logic [3:0] com_nxt;
  logic       boundary;
  logic       is_comma;

  // Window is the byte completed by the bit arriving on this edge.
  assign w        = {sr, data_in};
  assign com_nxt  = com_cnt + 4'd1;
  assign boundary = (bit_cnt == 3'd7);
  assign is_comma = (w == COM_SYMBOL);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr <= w[6:0];
      case (state)
        SEARCH: begin
          if (is_comma) begin
            state   <= ALIGN;
            com_cnt <= 4'd1;
            bit_cnt <= 3'd0;
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              com_cnt <= com_nxt;
              if (com_nxt == COM_COUNT_L) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              // A broken comma run restarts the sliding search on the next edge.
              state   <= SEARCH;
              com_cnt <= 4'd0;
            end
          end
        end
        LOCKED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            data_out  <= w;
            valid_out <= !is_comma;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: lock timing, misalignment, broken
// comma runs, commas while locked and asynchronous reset mid-operation.
module tb_serial_paralelo_rx;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int passes = 0;
  int total  = 0;

  serial_paralelo_rx #(.COM_SYMBOL(8'hBC), .COM_COUNT(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    chk({tag, ".data"}, data_out, d);
    chk({tag, ".valid"}, 8'(valid_out), 8'(v));
    chk({tag, ".active"}, 8'(active), 8'(a));
  endtask

  // Sends v[n-1:0] MSB first; returns 1 time unit after the last sampling edge.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = v[i];
      @(posedge clk_32f);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;

    // Held in reset with random serial data: outputs must stay cleared.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_32f);
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
      chk_out("reset_hold", 8'h00, 1'b0, 1'b0);
    end

    // Aligned lock: 4 commas, 0xA5, 0x3C.
    do_reset();
    repeat (3) send_byte(8'hBC);
    chk("aligned.active_e24", 8'(active), 8'd0);
    send_bits(8'h5E, 7);
    chk("aligned.active_e31", 8'(active), 8'd0);
    send_bits(8'h00, 1);
    chk_out("aligned.lock_e32", 8'h00, 1'b0, 1'b1);
    send_byte(8'hA5);
    chk_out("aligned.e40", 8'hA5, 1'b1, 1'b1);
    send_bits(8'h1E, 7);
    chk_out("aligned.e47", 8'hA5, 1'b1, 1'b1);
    send_bits(8'h00, 1);
    chk_out("aligned.e48", 8'h3C, 1'b1, 1'b1);

    // Misaligned start: 3 garbage bits then 4 commas and 0x5A.
    do_reset();
    send_bits(8'h05, 3);
    repeat (3) send_byte(8'hBC);
    send_bits(8'h5E, 7);
    chk("misaligned.active_e34", 8'(active), 8'd0);
    send_bits(8'h00, 1);
    chk_out("misaligned.lock_e35", 8'h00, 1'b0, 1'b1);
    send_byte(8'h5A);
    chk_out("misaligned.e43", 8'h5A, 1'b1, 1'b1);

    // Broken alignment: 3 commas, 0x00, 4 commas, 0x11.
    do_reset();
    repeat (3) send_byte(8'hBC);
    send_byte(8'h00);
    chk("broken.active_after_00", 8'(active), 8'd0);
    repeat (3) send_byte(8'hBC);
    chk("broken.active_after_7", 8'(active), 8'd0);
    send_byte(8'hBC);
    chk_out("broken.lock_e64", 8'h00, 1'b0, 1'b1);
    send_byte(8'h11);
    chk_out("broken.e72", 8'h11, 1'b1, 1'b1);

    // Comma while locked is passed through but flagged invalid.
    send_byte(8'h77);
    chk_out("locked.b77", 8'h77, 1'b1, 1'b1);
    send_byte(8'hBC);
    chk_out("locked.bBC", 8'hBC, 1'b0, 1'b1);
    send_byte(8'h88);
    chk_out("locked.b88", 8'h88, 1'b1, 1'b1);

    // Asynchronous reset mid-byte while locked.
    send_bits(8'h05, 3);
    @(negedge clk_32f);
    #1;
    reset = 1'b0;
    #1;
    chk_out("midreset.immediate", 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk_32f);
    chk_out("midreset.held", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) send_byte(8'hBC);
    chk_out("relock.after3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    chk_out("relock.after4", 8'h00, 1'b0, 1'b1);
    send_byte(8'h42);
    chk_out("relock.b42", 8'h42, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
